// File: rtl/hilo_md_unit.sv
// HI/LO register owner with a 32-step shift-add multiplier and restoring divider.
// Signed operations run on magnitudes; the sign fix-up happens in FIX.
module hilo_md_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        hiread,
  input  logic        loread,
  input  logic        flush,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        stall,
  output logic        done
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    FIX  = 2'b10
  } state_t;

  localparam logic [2:0] OP_MTHI = 3'b100;
  localparam logic [2:0] OP_MTLO = 3'b101;

  function automatic logic [31:0] abs32(input logic [31:0] x, input logic en);
    logic [31:0] r;
    if (en && x[31]) begin
      r = ~x + 32'd1;
    end else begin
      r = x;
    end
    return r;
  endfunction

  function automatic logic [31:0] cneg32(input logic [31:0] x, input logic en);
    logic [31:0] r;
    if (en) begin
      r = ~x + 32'd1;
    end else begin
      r = x;
    end
    return r;
  endfunction

  function automatic logic [63:0] cneg64(input logic [63:0] x, input logic en);
    logic [63:0] r;
    if (en) begin
      r = ~x + 64'd1;
    end else begin
      r = x;
    end
    return r;
  endfunction

  state_t      state_r, state_s;
  logic [31:0] hi_r, hi_s;
  logic [31:0] lo_r, lo_s;
  logic        busy_r, busy_s;
  logic        done_r, done_s;
  logic [4:0]  cnt_r, cnt_s;
  logic        is_div_r, is_div_s;
  logic        sgn_op_r, sgn_op_s;
  logic        sign_a_r, sign_a_s;
  logic        sign_b_r, sign_b_s;
  logic        div0_r, div0_s;
  logic [31:0] a_r, a_s;
  // multiplicand for multiply, divisor magnitude for divide
  logic [31:0] opb_r, opb_s;
  // multiply: product; divide: remainder in [63:32], quotient in [31:0]
  logic [63:0] acc_r, acc_s;

  logic        op_signed_s;
  logic [32:0] mul_sum_s;
  logic [63:0] mul_step_s;
  logic [32:0] rem_ext_s;
  logic [33:0] div_diff_s;
  logic [63:0] div_step_s;
  logic [63:0] prod_s;
  logic [31:0] quot_s;
  logic [31:0] remd_s;

  assign op_signed_s = ~op[0];

  // One iteration of each algorithm plus the signed result fix-up.
  always_comb begin
    mul_sum_s  = {1'b0, acc_r[63:32]} + (acc_r[0] ? {1'b0, opb_r} : 33'd0);
    mul_step_s = {mul_sum_s, acc_r[31:1]};
    rem_ext_s  = {acc_r[63:32], acc_r[31]};
    div_diff_s = {1'b0, rem_ext_s} - {2'b00, opb_r};
    if (!div_diff_s[33]) begin
      div_step_s = {div_diff_s[31:0], acc_r[30:0], 1'b1};
    end else begin
      div_step_s = {rem_ext_s[31:0], acc_r[30:0], 1'b0};
    end
    prod_s = cneg64(acc_r, sgn_op_r && (sign_a_r != sign_b_r));
    quot_s = cneg32(acc_r[31:0], sgn_op_r && (sign_a_r != sign_b_r));
    remd_s = cneg32(acc_r[63:32], sgn_op_r && sign_a_r);
  end

  // Next-state and next-register values for the sequencer.
  always_comb begin
    state_s  = state_r;
    hi_s     = hi_r;
    lo_s     = lo_r;
    done_s   = 1'b0;
    cnt_s    = cnt_r;
    is_div_s = is_div_r;
    sgn_op_s = sgn_op_r;
    sign_a_s = sign_a_r;
    sign_b_s = sign_b_r;
    div0_s   = div0_r;
    a_s      = a_r;
    opb_s    = opb_r;
    acc_s    = acc_r;
    case (state_r)
      IDLE: begin
        if (start && !flush) begin
          if (op == OP_MTHI) begin
            hi_s = a;
          end else if (op == OP_MTLO) begin
            lo_s = a;
          end else if (!op[2]) begin
            is_div_s = op[1];
            sgn_op_s = op_signed_s;
            sign_a_s = a[31] & op_signed_s;
            sign_b_s = b[31] & op_signed_s;
            a_s      = a;
            cnt_s    = 5'd0;
            if (op[1]) begin
              acc_s = {32'd0, abs32(a, op_signed_s)};
              opb_s = abs32(b, op_signed_s);
            end else begin
              acc_s = {32'd0, abs32(b, op_signed_s)};
              opb_s = abs32(a, op_signed_s);
            end
            if (op[1] && (b == 32'd0)) begin
              div0_s  = 1'b1;
              state_s = FIX;
            end else begin
              div0_s  = 1'b0;
              state_s = RUN;
            end
          end else begin
            state_s = IDLE;
          end
        end else begin
          state_s = IDLE;
        end
      end
      RUN: begin
        if (flush) begin
          state_s = IDLE;
        end else begin
          acc_s = is_div_r ? div_step_s : mul_step_s;
          cnt_s = cnt_r + 5'd1;
          if (cnt_r == 5'd31) begin
            state_s = FIX;
          end else begin
            state_s = RUN;
          end
        end
      end
      FIX: begin
        state_s = IDLE;
        if (!flush) begin
          done_s = 1'b1;
          if (div0_r) begin
            hi_s = a_r;
            lo_s = 32'hFFFF_FFFF;
          end else if (is_div_r) begin
            hi_s = remd_s;
            lo_s = quot_s;
          end else begin
            hi_s = prod_s[63:32];
            lo_s = prod_s[31:0];
          end
        end else begin
          done_s = 1'b0;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
    busy_s = (state_s != IDLE);
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r  <= IDLE;
      hi_r     <= 32'd0;
      lo_r     <= 32'd0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      cnt_r    <= 5'd0;
      is_div_r <= 1'b0;
      sgn_op_r <= 1'b0;
      sign_a_r <= 1'b0;
      sign_b_r <= 1'b0;
      div0_r   <= 1'b0;
      a_r      <= 32'd0;
      opb_r    <= 32'd0;
      acc_r    <= 64'd0;
    end else begin
      state_r  <= state_s;
      hi_r     <= hi_s;
      lo_r     <= lo_s;
      busy_r   <= busy_s;
      done_r   <= done_s;
      cnt_r    <= cnt_s;
      is_div_r <= is_div_s;
      sgn_op_r <= sgn_op_s;
      sign_a_r <= sign_a_s;
      sign_b_r <= sign_b_s;
      div0_r   <= div0_s;
      a_r      <= a_s;
      opb_r    <= opb_s;
      acc_r    <= acc_s;
    end
  end

  assign hi    = hi_r;
  assign lo    = lo_r;
  assign busy  = busy_r;
  assign done  = done_r;
  assign stall = busy_r & (start | hiread | loread);

endmodule

// File: tb/tb_hilo_md_unit.sv
// Self-checking bench for hilo_md_unit: directed cases plus randomized ops
// compared against a 64-bit arithmetic reference model.
module tb_hilo_md_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        hiread;
  logic        loread;
  logic        flush;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        stall;
  logic        done;

  int n_chk  = 0;
  int n_fail = 0;
  logic [31:0] mhi;
  logic [31:0] mlo;

  hilo_md_unit dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .hiread(hiread), .loread(loread), .flush(flush),
    .hi(hi), .lo(lo), .busy(busy), .stall(stall), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: architectural result computed with wide arithmetic.
  task automatic model_md(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                          output logic [31:0] eh, output logic [31:0] el, output int ecyc);
    longint      sp, sq, sr;
    logic [63:0] up, uq, ur;
    ecyc = 33;
    eh = 32'd0;
    el = 32'd0;
    case (o)
      3'b000: begin
        sp = longint'($signed(x)) * longint'($signed(y));
        eh = sp[63:32]; el = sp[31:0];
      end
      3'b001: begin
        up = {32'd0, x} * {32'd0, y};
        eh = up[63:32]; el = up[31:0];
      end
      default: begin
        if (y == 32'd0) begin
          eh = x; el = 32'hFFFF_FFFF; ecyc = 1;
        end else if (o == 3'b010) begin
          sq = longint'($signed(x)) / longint'($signed(y));
          sr = longint'($signed(x)) % longint'($signed(y));
          eh = sr[31:0]; el = sq[31:0];
        end else begin
          uq = {32'd0, x} / {32'd0, y};
          ur = {32'd0, x} % {32'd0, y};
          eh = ur[31:0]; el = uq[31:0];
        end
      end
    endcase
  endtask

  task automatic run_md(input string tag, input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    logic [31:0] eh, el;
    int ecyc, cyc;
    logic hold_bad;
    model_md(o, x, y, eh, el, ecyc);
    start = 1'b1; op = o; a = x; b = y;
    @(negedge clk);
    start = 1'b0; a = $urandom; b = $urandom;
    cyc = 0;
    hold_bad = 1'b0;
    while (busy === 1'b1 && cyc < 50) begin
      if (hi !== mhi || lo !== mlo || done !== 1'b0) hold_bad = 1'b1;
      cyc++;
      @(negedge clk);
    end
    chk({tag, " busy_cycles"}, 32'(cyc), 32'(ecyc));
    chk({tag, " hold"}, {31'd0, hold_bad}, 32'd0);
    chk({tag, " done"}, {31'd0, done}, 32'd1);
    chk({tag, " hi"}, hi, eh);
    chk({tag, " lo"}, lo, el);
    mhi = eh; mlo = el;
    @(negedge clk);
    chk({tag, " done_off"}, {31'd0, done}, 32'd0);
  endtask

  task automatic run_flush(input string tag, input logic [2:0] o, input logic [31:0] x,
                           input logic [31:0] y, input int at);
    start = 1'b1; op = o; a = x; b = y;
    @(negedge clk);
    start = 1'b0;
    repeat (at) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk({tag, " busy"}, {31'd0, busy}, 32'd0);
    chk({tag, " done"}, {31'd0, done}, 32'd0);
    chk({tag, " hi"}, hi, mhi);
    chk({tag, " lo"}, lo, mlo);
    @(negedge clk);
    chk({tag, " done_late"}, {31'd0, done}, 32'd0);
  endtask

  task automatic run_mt(input string tag, input logic [2:0] o, input logic [31:0] x, input logic fl);
    start = 1'b1; op = o; a = x; flush = fl;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    if (!fl && o == 3'b100) mhi = x;
    if (!fl && o == 3'b101) mlo = x;
    chk({tag, " hi"}, hi, mhi);
    chk({tag, " lo"}, lo, mlo);
    chk({tag, " busy"}, {31'd0, busy}, 32'd0);
    chk({tag, " done"}, {31'd0, done}, 32'd0);
  endtask

  initial begin
    int cyc;
    logic [31:0] x, y, xlo;
    logic [2:0] o;
    logic [31:0] eh, el;
    int ecyc;
    rst = 1'b1; start = 1'b0; op = 3'b000; a = 32'd0; b = 32'd0;
    hiread = 1'b0; loread = 1'b0; flush = 1'b0;
    mhi = 32'd0; mlo = 32'd0;
    #12;
    chk("rst hi", hi, 32'd0);
    chk("rst lo", lo, 32'd0);
    chk("rst busy", {31'd0, busy}, 32'd0);
    chk("rst done", {31'd0, done}, 32'd0);
    chk("rst stall", {31'd0, stall}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    run_md("mult", 3'b000, 32'hFFFF_FFFE, 32'd3);
    run_md("multu", 3'b001, 32'hFFFF_FFFE, 32'd3);
    run_md("divu", 3'b011, 32'd100, 32'd7);
    run_md("div_neg", 3'b010, 32'hFFFF_FFF9, 32'd2);
    run_md("div_ovf", 3'b010, 32'h8000_0000, 32'hFFFF_FFFF);
    run_md("div0", 3'b010, 32'd5, 32'd0);

    // MFHI during MULT stalls; MTLO held by the pipeline until the unit frees up
    start = 1'b1; op = 3'b000; a = 32'd1234; b = 32'd5678;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    hiread = 1'b1;
    #1 chk("stall_hiread", {31'd0, stall}, 32'd1);
    @(negedge clk);
    hiread = 1'b0;
    start = 1'b1; op = 3'b101; a = 32'hCAFE_F00D;
    #1 chk("stall_mtlo", {31'd0, stall}, 32'd1);
    cyc = 0;
    while (busy === 1'b1 && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    chk("stall_release", {31'd0, stall}, 32'd0);
    chk("stall_mult_lo", lo, 32'd7006652);
    chk("stall_done", {31'd0, done}, 32'd1);
    @(negedge clk);
    start = 1'b0;
    mhi = 32'd0; mlo = 32'hCAFE_F00D;
    chk("mtlo_after", lo, mlo);
    chk("mtlo_hi", hi, mhi);

    run_mt("mthi", 3'b100, 32'h0000_1234, 1'b0);
    run_flush("flush_divu", 3'b011, 32'd9, 32'd2, 9);
    run_mt("mtlo_flush", 3'b101, 32'hDEAD_BEEF, 1'b1);
    run_mt("op_ignored", 3'b110, 32'h5555_AAAA, 1'b0);

    // back-to-back: accept a new op in the done cycle
    run_md("b2b_a", 3'b001, 32'd3, 32'd4);
    model_md(3'b011, 32'd50, 32'd6, eh, el, ecyc);
    start = 1'b1; op = 3'b001; a = 32'd7; b = 32'd8;
    @(negedge clk);
    start = 1'b0;
    while (busy === 1'b1 && cyc < 200) begin @(negedge clk); cyc++; end
    start = 1'b1; op = 3'b011; a = 32'd50; b = 32'd6;
    chk("b2b_first_lo", lo, 32'd56);
    mhi = 32'd0; mlo = 32'd56;
    @(negedge clk);
    start = 1'b0;
    chk("b2b_accept", {31'd0, busy}, 32'd1);
    cyc = 0;
    while (busy === 1'b1 && cyc < 50) begin @(negedge clk); cyc++; end
    chk("b2b_second_hi", hi, eh);
    chk("b2b_second_lo", lo, el);
    mhi = eh; mlo = el;
    @(negedge clk);

    for (int i = 0; i < 40; i++) begin
      x = $urandom;
      y = $urandom;
      if ($urandom_range(0, 5) == 0) x = 32'h8000_0000;
      if ($urandom_range(0, 5) == 0) y = 32'hFFFF_FFFF;
      case ($urandom_range(0, 9))
        0: run_mt("rnd_mthi", 3'b100, x, 1'b0);
        1: run_mt("rnd_mtlo", 3'b101, x, 1'b0);
        9: run_mt("rnd_ign", 3'b111, x, 1'b0);
        default: begin
          o = 3'($urandom_range(0, 3));
          if (o[1] && $urandom_range(0, 7) == 0) y = 32'd0;
          if ($urandom_range(0, 4) == 0) begin
            model_md(o, x, y, eh, el, ecyc);
            run_flush("rnd_flush", o, x, y, (ecyc == 1) ? 0 : int'($urandom_range(0, 32)));
          end else begin
            run_md("rnd_md", o, x, y);
          end
        end
      endcase
    end

    // asynchronous reset between edges in the middle of a divide
    start = 1'b1; op = 3'b011; a = 32'hFFFF_0000; b = 32'd3;
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst hi", hi, 32'd0);
    chk("arst lo", lo, 32'd0);
    chk("arst busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    xlo = 32'd0;
    repeat (40) begin
      @(negedge clk);
      if (done !== 1'b0 || busy !== 1'b0) xlo = 32'd1;
    end
    chk("arst no_done", xlo, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
